i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Two-requester arbiter and transaction sequencer for the shared `i2c_master`. It picks one pending byte request round-robin and latches that request's direction and write byte. It then holds the master enabled until the master reports completion, and returns the read byte and a completion pulse to the winner. It sits between the system-side requesters and the single `i2c_master` instance that drives `scl`/`sda`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: maximum cycles a granted transaction may stay in BUSY. Used only when the watchdog is compiled in.
- `CNT_W`, 13: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous active-low reset (asserted at 0).
- `req`  in  2  per-requester request level; held until the matching `done` pulse.
- `rw`  in  2  per-requester direction; 1 = read, 0 = write. Sampled at grant.
- `wdata0`  in  8  requester 0 write byte. Sampled at grant.
- `wdata1`  in  8  requester 1 write byte. Sampled at grant.
- `gnt`  out  2  one-hot grant; held from grant until DONE.
- `done`  out  2  one-cycle completion pulse to the granted requester.
- `err`  out  1  one-cycle pulse, coincident with `done`, when the transaction was aborted.
- `rdata`  out  8  read byte. Valid from the `done` pulse until the next `done`.
- `m_enable`  out  1  to `i2c_master` enable.
- `m_read_write`  out  1  to `i2c_master` read_write.
- `m_data_write`  out  8  to `i2c_master` data_write.
- `m_data`  in  8  from `i2c_master` data.
- `m_done`  in  1  single-cycle pulse from the master at the end of the byte (ACK/NACK phase complete).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - When `req != 0`, select the winner.
  - If only one bit is set, that requester wins.
  - If both are set, the requester opposite `last` wins. `last` is a 1-bit register holding the previous winner; its reset value is 1, so requester 0 wins the first tie.
  - Latch `rw` and `wdata` of the winner into `m_read_write` and `m_data_write`, set `gnt`, and go to BUSY.
- BUSY
  - `m_enable` = 1.
  - On `m_done`: capture `m_data` into `rdata` if the direction is read (write transactions leave `rdata` unchanged), then go to DONE.
- DONE
  - Pulse `done[winner]`, deassert `m_enable`, clear `gnt`, set `last` = winner, and go to IDLE.
  - The next grant occurs no earlier than the following cycle.
- `m_done` is ignored in IDLE and DONE.
- A requester dropping `req` during BUSY does not abort the transaction; it still receives `done`.
- Reset (async, any state): state = IDLE; `gnt`, `done`, `err`, `m_enable`, `m_read_write` = 0; `rdata` and `m_data_write` = 8'h00; `last` = 1; watchdog counter = 0.

## Timing
- Grant latency: `req` rising in IDLE gives `gnt` and `m_enable` high on the next clock edge.
- Completion: `m_done` in cycle N gives DONE at edge N+1. `done` and `rdata` are visible in cycle N+1, and `m_enable` is low from N+1.
- Minimum gap between back-to-back grants: 1 IDLE cycle.
- All outputs are registered; there is no combinational path from the requester inputs to the master-side outputs.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - The watchdog counter increments every BUSY cycle and is cleared on entry to BUSY.
  - When the count reaches `TIMEOUT_CYCLES-1` without `m_done`, the block goes to DONE with `err` = 1 and leaves `rdata` unchanged.
  - If `m_done` arrives in the same cycle as the timeout, `m_done` wins and `err` = 0.
- `I2C_ARB_TIMEOUT_EN` undefined:
  - No counter is built, and `err` is tied to 0.
  - BUSY waits indefinitely for `m_done`.

## Structure
- Package `i2c_arb_pkg` contains:
  - the state enum (IDLE, BUSY, DONE);
  - `NUM_REQ` = 2;
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `i2c_rr_pick`: combinational round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: one-hot `pick[1:0]`, `valid`.
- The watchdog lives inline under the macro.

## Test plan
- Single write: `req[0]`=1, `rw[0]`=0, `wdata0`=8'hB3.
  - Next edge: `gnt`=01, `m_data_write`=B3, `m_read_write`=0, `m_enable`=1.
  - Model `m_done` 40 cycles later: `done`=01 one cycle after, `err`=0, `rdata` unchanged (00).
- Single read: `req[1]`, `rw[1]`=1, model returns `m_data`=8'hBC with `m_done`.
  - `done`=10 and `rdata`=BC.
- Simultaneous `req`=11 after reset, each request held until its `done`:
  - grant order 0, 1, 0, 1 over four transactions;
  - no overlap in `gnt`;
  - at least one IDLE cycle between grants.
- Timeout (macro on, `TIMEOUT_CYCLES`=16), no `m_done`:
  - `done` and `err` pulse together 16 BUSY cycles after grant;
  - `m_enable` drops;
  - with the macro off, the block stays in BUSY for 100 cycles.
- Async reset (`rst`=0) mid-BUSY:
  - all outputs go to their reset values immediately, without a clock edge;
  - after release, `req`=11 grants requester 0.
- Stray `m_done` in IDLE: no `done` pulse and no change to `rdata`.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the i2c_master arbiter
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int NUM_REQ            = 2;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational two-way round-robin picker
module i2c_rr_pick
  import i2c_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  always_comb begin
    pick  = '0;
    valid = |req;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      // on a tie the requester that did not win last time goes first
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - two-requester arbiter and sequencer for i2c_master
// Optional BUSY watchdog compiled in with I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rw,
  input  logic [7:0]         wdata0,
  input  logic [7:0]         wdata1,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  output logic [7:0]         rdata,
  output logic               m_enable,
  output logic               m_read_write,
  output logic [7:0]         m_data_write,
  input  logic [7:0]         m_data,
  input  logic               m_done
);

  arb_state_t         state_q, state_n;
  logic               win_q, win_n;
  logic               last_q, last_n;
  logic [NUM_REQ-1:0] gnt_n, done_n;
  logic               err_n;
  logic [7:0]         rdata_n;
  logic               men_n, mrw_n;
  logic [7:0]         mdw_n;
  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic               timeout_hit;

  i2c_rr_pick u_pick (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_n;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    win_n   = win_q;
    last_n  = last_q;
    gnt_n   = gnt;
    done_n  = '0;
    err_n   = 1'b0;
    rdata_n = rdata;
    men_n   = m_enable;
    mrw_n   = m_read_write;
    mdw_n   = m_data_write;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_n   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_n = BUSY;
          gnt_n   = pick;
          win_n   = pick[1];
          men_n   = 1'b1;
          mrw_n   = pick[1] ? rw[1] : rw[0];
          mdw_n   = pick[1] ? wdata1 : wdata0;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      BUSY: begin
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_n = cnt_q + 1'b1;
`endif
        // m_done takes priority over a coincident timeout
        if (m_done || timeout_hit) begin
          state_n = DONE;
          done_n  = win_q ? 2'b10 : 2'b01;
          err_n   = !m_done;
          gnt_n   = '0;
          men_n   = 1'b0;
          if (m_done && m_read_write) rdata_n = m_data;
        end
      end
      DONE: begin
        last_n  = win_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      win_q        <= 1'b0;
      last_q       <= 1'b1;
      gnt          <= '0;
      done         <= '0;
      err          <= 1'b0;
      rdata        <= 8'h00;
      m_enable     <= 1'b0;
      m_read_write <= 1'b0;
      m_data_write <= 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_n;
      win_q        <= win_n;
      last_q       <= last_n;
      gnt          <= gnt_n;
      done         <= done_n;
      err          <= err_n;
      rdata        <= rdata_n;
      m_enable     <= men_n;
      m_read_write <= mrw_n;
      m_data_write <= mdw_n;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q        <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, rw;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, done;
  logic       err;
  logic [7:0] rdata;
  logic       m_enable, m_read_write;
  logic [7:0] m_data_write, m_data;
  logic       m_done;

  int tests  = 0;
  int failed = 0;

  i2c_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .rw           (rw),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .m_enable     (m_enable),
    .m_read_write (m_read_write),
    .m_data_write (m_data_write),
    .m_data       (m_data),
    .m_done       (m_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " gnt"},  32'(gnt), 32'h0);
    check({tag, " done"}, 32'(done), 32'h0);
    check({tag, " err"},  32'(err), 32'h0);
    check({tag, " men"},  32'(m_enable), 32'h0);
    check({tag, " mrw"},  32'(m_read_write), 32'h0);
    check({tag, " mdw"},  32'(m_data_write), 32'h00);
    check({tag, " rdata"}, 32'(rdata), 32'h00);
  endtask

  initial begin
    rst = 1'b0; req = 2'b00; rw = 2'b00; wdata0 = 8'h00; wdata1 = 8'h00;
    m_data = 8'h00; m_done = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // single write from requester 0
    req = 2'b01; rw = 2'b00; wdata0 = 8'hB3; wdata1 = 8'h55;
    tick();
    check("wr gnt", 32'(gnt), 32'h1);
    check("wr mdw", 32'(m_data_write), 32'hB3);
    check("wr mrw", 32'(m_read_write), 32'h0);
    check("wr men", 32'(m_enable), 32'h1);
    repeat (39) tick();
    check("wr no early done", 32'(done), 32'h0);
    m_data = 8'hEE; m_done = 1'b1;
    tick();
    m_done = 1'b0;
    check("wr done", 32'(done), 32'h1);
    check("wr err", 32'(err), 32'h0);
    check("wr rdata kept", 32'(rdata), 32'h00);
    check("wr men low", 32'(m_enable), 32'h0);
    check("wr gnt clear", 32'(gnt), 32'h0);
    req = 2'b00;
    tick();
    check("wr done pulse", 32'(done), 32'h0);

    // single read from requester 1
    req = 2'b10; rw = 2'b10; wdata1 = 8'h5A;
    tick();
    check("rd gnt", 32'(gnt), 32'h2);
    check("rd mrw", 32'(m_read_write), 32'h1);
    check("rd mdw", 32'(m_data_write), 32'h5A);
    repeat (5) tick();
    m_data = 8'hBC; m_done = 1'b1;
    tick();
    m_done = 1'b0;
    check("rd done", 32'(done), 32'h2);
    check("rd rdata", 32'(rdata), 32'hBC);
    req = 2'b00; rw = 2'b00;
    tick(); tick();

    // stray m_done in IDLE
    m_data = 8'h77; m_done = 1'b1;
    tick();
    m_done = 1'b0;
    check("stray done", 32'(done), 32'h0);
    check("stray rdata", 32'(rdata), 32'hBC);
    check("stray gnt", 32'(gnt), 32'h0);
    tick();

    // async reset in the middle of BUSY
    req = 2'b01;
    tick();
    check("pre-rst men", 32'(m_enable), 32'h1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async rst");
    #1 rst = 1'b1; req = 2'b11;

    // tie after reset: alternating grants, gap between them
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      if (k > 0) begin
        tick();
        check($sformatf("tie gap %0d", k), 32'(gnt), 32'h0);
        tick();
      end
      check($sformatf("tie gnt %0d", k), 32'(gnt), 32'(exp_g));
      repeat (3) tick();
      m_data = 8'(k); m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check($sformatf("tie done %0d", k), 32'(done), 32'(exp_g));
    end
    req = 2'b00;
    tick(); tick();

    // watchdog behaviour
    req = 2'b01;
    tick();
    check("to gnt", 32'(gnt), 32'h1);
`ifdef I2C_ARB_TIMEOUT_EN
    repeat (15) tick();
    check("to not yet", 32'(done), 32'h0);
    tick();
    check("to done", 32'(done), 32'h1);
    check("to err", 32'(err), 32'h1);
    check("to men", 32'(m_enable), 32'h0);
    check("to rdata", 32'(rdata), 32'h00);
    req = 2'b00;
    tick();
    check("to err pulse", 32'(err), 32'h0);
`else
    repeat (100) tick();
    check("nto still gnt", 32'(gnt), 32'h1);
    check("nto still men", 32'(m_enable), 32'h1);
    check("nto no done", 32'(done), 32'h0);
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    check("nto done", 32'(done), 32'h1);
    check("nto err", 32'(err), 32'h0);
    req = 2'b00;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
